dm_cache_wb_ctrl: RTL

//  Parametrised direct-mapped, write-back, write-allocate cache (data, tag, valid and dirty arrays plus controller).

---
 rtl/cache_pkg.sv | 29 ++
 rtl/dm_cache_store.sv | 77 +++++++
 rtl/dm_cache_wb_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address slicing helpers for the direct-mapped cache
// Purpose: controller state encoding plus byte-address field extraction.
// Helpers take the field widths as arguments so any OFF_W/IDX_W can share them;
// callers cast the 64-bit result down to the field width they need.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_e;

  // Word offset inside the block; byte bits [1:0] are skipped.
  function automatic logic [63:0] addr_off(input logic [63:0] addr, input int unsigned off_w);
    return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_idx(input logic [63:0] addr, input int unsigned off_w,
                                           input int unsigned idx_w);
    return (addr >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned off_w,
                                           input int unsigned idx_w);
    return addr >> (off_w + idx_w + 2);
  endfunction

endpackage

// File: rtl/dm_cache_store.sv
// rtl/dm_cache_store.sv - data/tag/valid/dirty arrays of the direct-mapped cache
// Purpose: line storage with synchronous writes and combinational reads at one index.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valid and dirty only)
//   idx, off            line index and word offset for both read and write
//   word_we, word_wdata store one word into the line and mark it dirty
//   blk_we, blk_wdata,  refill a whole line: data and tag written, valid set, dirty cleared
//   blk_tag
//   dirty_clr           clear dirty after the victim has been written back
//   rd_blk/rd_tag/rd_valid/rd_dirty  current contents of line idx
module dm_cache_store #(
  parameter int WORD_W      = 32,
  parameter int WORDS_PER_B = 4,
  parameter int NUM_BLOCKS  = 32,
  parameter int TAG_W       = 23,
  localparam int OFF_W      = $clog2(WORDS_PER_B),
  localparam int IDX_W      = $clog2(NUM_BLOCKS),
  localparam int BLK_W      = WORD_W * WORDS_PER_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [OFF_W-1:0]  off,
  input  logic              word_we,
  input  logic [WORD_W-1:0] word_wdata,
  input  logic              blk_we,
  input  logic [BLK_W-1:0]  blk_wdata,
  input  logic [TAG_W-1:0]  blk_tag,
  input  logic              dirty_clr,
  output logic [BLK_W-1:0]  rd_blk,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty
);

  logic [BLK_W-1:0]      data_mem [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;

  // Data and tag arrays are deliberately left unreset; valid gates their use.
  always_ff @(posedge clk) begin
    if (blk_we) begin
      data_mem[idx] <= blk_wdata;
      tag_mem[idx]  <= blk_tag;
    end else if (word_we) begin
      data_mem[idx][off*WORD_W +: WORD_W] <= word_wdata;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (blk_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (word_we)   dirty_d[idx] = 1'b1;
    if (dirty_clr) dirty_d[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_blk   = data_mem[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/dm_cache_wb_ctrl.sv
// rtl/dm_cache_wb_ctrl.sv - direct-mapped write-back write-allocate cache controller
// Purpose: accepts one core load/store at a time, hits in one cycle, on a miss writes back a
// dirty victim, refills the block and re-runs the compare; keeps saturating hit/miss counters.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req_valid/ready, cpu_we,     core request (ready only while idle)
//   cpu_addr, cpu_wdata
//   cpu_resp_valid, cpu_rdata        one-cycle completion pulse, load data (0 for stores)
//   mem_req_valid/ready, mem_we,     block memory request, held until accepted
//   mem_addr, mem_wdata
//   mem_resp_valid, mem_rdata        refill data return
//   hit_count, miss_count            first-compare statistics
module dm_cache_wb_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int WORDS_PER_B = 4,
  parameter int NUM_BLOCKS  = 32,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32,
  localparam int OFF_W      = $clog2(WORDS_PER_B),
  localparam int IDX_W      = $clog2(NUM_BLOCKS),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W - 2,
  localparam int BLK_W      = WORD_W * WORDS_PER_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [BLK_W-1:0]  mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_e            state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] req_wdata_q, req_wdata_d;
  logic              first_cmp_q, first_cmp_d;
  logic              refill_sent_q, refill_sent_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [BLK_W-1:0]  rd_blk;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid, rd_dirty;
  logic              word_we, blk_we, dirty_clr;
  logic              hit, refill_done;

  assign req_off = OFF_W'(addr_off(64'(req_addr_q), OFF_W));
  assign req_idx = IDX_W'(addr_idx(64'(req_addr_q), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_tag(64'(req_addr_q), OFF_W, IDX_W));

  dm_cache_store #(
    .WORD_W      (WORD_W),
    .WORDS_PER_B (WORDS_PER_B),
    .NUM_BLOCKS  (NUM_BLOCKS),
    .TAG_W       (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .idx        (req_idx),
    .off        (req_off),
    .word_we    (word_we),
    .word_wdata (req_wdata_q),
    .blk_we     (blk_we),
    .blk_wdata  (mem_rdata),
    .blk_tag    (req_tag),
    .dirty_clr  (dirty_clr),
    .rd_blk     (rd_blk),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty)
  );

  assign hit = rd_valid && (rd_tag == req_tag);
  // Response may arrive in the same cycle the refill request is accepted.
  assign refill_done = (state_q == REFILL) && mem_resp_valid && (refill_sent_q || mem_req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      first_cmp_q   <= 1'b0;
      refill_sent_q <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      first_cmp_q   <= first_cmp_d;
      refill_sent_q <= refill_sent_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cpu_req_valid) state_d = COMPARE;
      COMPARE:   state_d = hit ? IDLE : (rd_dirty ? WRITEBACK : REFILL);
      WRITEBACK: if (mem_req_ready) state_d = REFILL;
      REFILL:    if (refill_done) state_d = COMPARE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_resp_valid = 1'b0;
    cpu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    word_we        = 1'b0;
    blk_we         = 1'b0;
    dirty_clr      = 1'b0;
    case (state_q)
      COMPARE: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          if (req_we_q) word_we = 1'b1;
          else          cpu_rdata = rd_blk[req_off*WORD_W +: WORD_W];
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = {rd_tag, req_idx, {(OFF_W+2){1'b0}}};
        mem_wdata     = rd_blk;
        dirty_clr     = mem_req_ready;
      end
      REFILL: begin
        mem_req_valid = !refill_sent_q;
        mem_addr      = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
        blk_we        = refill_done;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    first_cmp_d   = first_cmp_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    refill_sent_d = (state_q == REFILL) ? refill_sent_q : 1'b0;
    if (state_q == IDLE && cpu_req_valid) begin
      req_we_d    = cpu_we;
      req_addr_d  = cpu_addr;
      req_wdata_d = cpu_wdata;
      first_cmp_d = 1'b1;
    end
    // Only the first compare of a request is counted; the post-refill one is not.
    if (state_q == COMPARE) begin
      first_cmp_d = 1'b0;
      if (first_cmp_q) begin
        if (hit) begin
          if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
        end else begin
          if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
        end
      end
    end
    if (state_q == REFILL && !refill_sent_q && mem_req_ready) refill_sent_d = 1'b1;
    if (refill_done) refill_sent_d = 1'b0;
  end

  assign cpu_req_ready = (state_q == IDLE);
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

endmodule
